mem_access_serial_tracker: RTL
==============================

# mem_access_serial_tracker

Parametrised allocator and tracker for outstanding memory read transactions, replacing the fixed `MSHR_NUM+1` serial scheme. Sits between the D-cache MSHRs, the I-cache and the memory port. It arbitrates N requesters round-robin and hands out free `MemAccessSerial` IDs from a pool of configurable depth. It records each ID's owner and routes each memory response back to the owning requester, freeing the ID.

## Interface
Parameters:
- `REQ_PORT_NUM`, 3: number of requesters (MSHR_NUM D-cache + 1 I-cache); ≥1.
- `SERIAL_NUM`, 4: pool depth; power of two, ≥2; serial width `SERIAL_BIT = $clog2(SERIAL_NUM)`.
- `TIMEOUT_CYCLES`, 1024: age limit, used only with the timeout feature.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-low.
- `reqValid` in REQ_PORT_NUM: per-requester allocation request.
- `reqAck` out REQ_PORT_NUM: one-hot grant; the request is issued this cycle.
- `reqSerial` out SERIAL_BIT: serial assigned to the granted requester.
- `memReqValid` out 1: request forwarded to the memory port.
- `memReqReady` in 1: memory port accepts this cycle.
- `respValid` in 1: memory read response.
- `respSerial` in SERIAL_BIT: serial of the response.
- `respPortValid` out REQ_PORT_NUM: one-hot; response belongs to this requester.
- `outstandingCount` out SERIAL_BIT+1: number of live serials.
- `full` out 1: no free serial.
- `protocolError` out 1: sticky; set by a response to a non-live serial.
- `timeout` out 1: sticky timeout flag (0 when the feature is compiled out).
- `timeoutSerial` out SERIAL_BIT: first serial that timed out.

## Operation
- Per-entry state: `valid` and `owner` (port index).
- Allocation, combinational within a cycle:
  - Grant requires `|reqValid`, `!full` and `memReqReady`.
  - Winner is the first set `reqValid` at or after the round-robin pointer, wrapping around.
  - Serial is the lowest-index free entry.
  - `memReqValid = reqAck != 0`.
- At the clock edge after a grant: entry valid=1, owner=winner; pointer = winner+1 mod REQ_PORT_NUM. The pointer is unchanged when there is no grant.
- Response to a live serial:
  - `respPortValid[owner]=1` in the same cycle (combinational).
  - Entry cleared at the edge.
  - A freed ID is not reallocatable in the same cycle (no bypass).
- Response to a non-live serial: `respPortValid=0`; `protocolError` set at the edge and held until reset.
- Simultaneous grant and release: both happen and `outstandingCount` is unchanged. The granted serial is never the one being released in that cycle.
- `full = (outstandingCount == SERIAL_NUM)`. With `full` set, every `reqAck` is 0 regardless of `reqValid`.
- Requesters may drop `reqValid` without a grant; no state is kept for them.

## Timing
- Grant latency is 0 cycles: `reqAck` and `reqSerial` are valid in the cycle of `reqValid`.
- Response routing latency is 0 cycles; the ID is free from the next cycle.
- Reset (asynchronous, mid-operation included):
  - All entries invalid.
  - Pointer 0.
  - `outstandingCount`=0, `full`=0, `protocolError`=0, `timeout`=0, `timeoutSerial`=0.
  - `reqAck`=0, `memReqValid`=0, `respPortValid`=0 (combinational outputs follow the cleared state).
  - In-flight responses are lost; the memory side is reset together with this block.
- Throughput is one allocation and one release per cycle.

## Configuration
- `RSD_MEM_SERIAL_TIMEOUT_EN` defined:
  - Each entry has an age counter of width `$clog2(TIMEOUT_CYCLES)+1`, cleared on allocation and incremented each cycle while valid.
  - When an age reaches `TIMEOUT_CYCLES`, `timeout` is set at the next edge and `timeoutSerial` latches the lowest such index. Both are sticky; the entry stays live.
- Not defined: no counters; `timeout`=0 and `timeoutSerial`=0 constantly.

## Structure
- Add to `CacheSystemTypes`:
  - `MEM_SERIAL_TRACKER_REQ_PORT_NUM` and `MEM_SERIAL_TRACKER_SERIAL_NUM`.
  - `MemSerialTrackerEntry` struct {valid, owner}.
  - Derive `MEM_ACCESS_SERIAL_BIT_SIZE` from the serial-num constant.
- One sub-module: `mem_serial_rr_arbiter` (request vector and pointer in, one-hot grant out, combinational).

## Test plan
- Reset, then port0 requests with memReqReady=1 -> reqAck=001, reqSerial=0, memReqValid=1; next cycle outstandingCount=1.
- All three ports request continuously with SERIAL_NUM=4 -> grants 0,1,2,0 with serials 0,1,2,3; then full=1 and reqAck=000.
- Full pool; respValid serial 2 (owner port2) while port1 requests -> respPortValid=100 and reqAck=000; next cycle port1 gets serial 2.
- One live serial; grant of serial 1 plus response on serial 0 in the same cycle -> outstandingCount unchanged at 1, serial 0 freed.
- respValid on unallocated serial 3 -> respPortValid=000, protocolError=1 from the next cycle and held; rst low mid-stream -> all outputs 0 immediately.
- With RSD_MEM_SERIAL_TIMEOUT_EN and TIMEOUT_CYCLES=16: serial 0 allocated and never answered -> timeout=1 and timeoutSerial=0 at cycle 17 after allocation.

Source files
------------

// File: rtl/mem_access_serial_tracker_pkg.sv
// Shared constants and types for the memory-access serial tracker.
// Default sizes: 2 D-cache MSHRs + 1 I-cache requester, pool of 4 serials.
package mem_access_serial_tracker_pkg;

  // Width of a port index. It is never zero, so a single requester still has a legal vector.
  function automatic int port_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int MEM_SERIAL_TRACKER_REQ_PORT_NUM = 3;
  localparam int MEM_SERIAL_TRACKER_SERIAL_NUM   = 4;
  localparam int MEM_ACCESS_SERIAL_BIT_SIZE      = $clog2(MEM_SERIAL_TRACKER_SERIAL_NUM);
  localparam int MEM_SERIAL_TRACKER_OWNER_BIT    = port_bits(MEM_SERIAL_TRACKER_REQ_PORT_NUM);

  typedef logic [MEM_ACCESS_SERIAL_BIT_SIZE-1:0]   MemAccessSerial;
  typedef logic [MEM_SERIAL_TRACKER_OWNER_BIT-1:0] MemSerialOwner;

  typedef struct packed {
    logic          valid;
    MemSerialOwner owner;
  } MemSerialTrackerEntry;

endpackage

// File: rtl/mem_access_serial_tracker_if.sv
// Requester/memory-side bus of the serial tracker. The tracker connects through
// the slave modport; the cache/memory environment connects through the master modport.
interface mem_access_serial_tracker_if #(
  parameter int REQ_PORT_NUM = 3,
  parameter int SERIAL_NUM   = 4
);
  localparam int SERIAL_BIT = $clog2(SERIAL_NUM);

  logic [REQ_PORT_NUM-1:0] reqValid;
  logic [REQ_PORT_NUM-1:0] reqAck;
  logic [SERIAL_BIT-1:0]   reqSerial;
  logic                    memReqValid;
  logic                    memReqReady;
  logic                    respValid;
  logic [SERIAL_BIT-1:0]   respSerial;
  logic [REQ_PORT_NUM-1:0] respPortValid;
  logic [SERIAL_BIT:0]     outstandingCount;
  logic                    full;
  logic                    protocolError;
  logic                    timeout;
  logic [SERIAL_BIT-1:0]   timeoutSerial;

  modport master (
    output reqValid, memReqReady, respValid, respSerial,
    input  reqAck, reqSerial, memReqValid, respPortValid,
           outstandingCount, full, protocolError, timeout, timeoutSerial
  );

  modport slave (
    input  reqValid, memReqReady, respValid, respSerial,
    output reqAck, reqSerial, memReqValid, respPortValid,
           outstandingCount, full, protocolError, timeout, timeoutSerial
  );

endinterface

// File: rtl/mem_access_serial_tracker_arbiter.sv
// Combinational round-robin arbiter: the first request at or after the pointer,
// wrapping around, receives a one-hot grant.
module mem_serial_rr_arbiter
  import mem_access_serial_tracker_pkg::*;
#(
  parameter int PORT_NUM = 3,
  parameter int PTR_BIT  = port_bits(PORT_NUM)
) (
  input  logic [PORT_NUM-1:0] req_i,
  input  logic [PTR_BIT-1:0]  ptr_i,
  output logic [PORT_NUM-1:0] grant_o
);

  logic               found;
  logic [PTR_BIT-1:0] idx;

  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    idx     = '0;
    for (int off = 0; off < PORT_NUM; off++) begin
      idx = PTR_BIT'((int'(ptr_i) + off) % PORT_NUM);
      if (!found && req_i[idx]) begin
        grant_o[idx] = 1'b1;
        found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_access_serial_tracker.sv
// Allocates MemAccessSerial IDs to round-robin-arbitrated requesters and routes
// memory responses back to their owners. The optional per-entry age watchdog is
// enabled by defining RSD_MEM_SERIAL_TIMEOUT_EN.
module mem_access_serial_tracker
  import mem_access_serial_tracker_pkg::*;
#(
  parameter int REQ_PORT_NUM   = MEM_SERIAL_TRACKER_REQ_PORT_NUM,
  parameter int SERIAL_NUM     = MEM_SERIAL_TRACKER_SERIAL_NUM,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic                         clk,
  input logic                         rst,
  mem_access_serial_tracker_if.slave  bus
);

  localparam int SERIAL_BIT = $clog2(SERIAL_NUM);
  localparam int OWNER_BIT  = port_bits(REQ_PORT_NUM);
  localparam int COUNT_BIT  = SERIAL_BIT + 1;

  typedef logic [OWNER_BIT-1:0] owner_t;
  typedef struct packed {
    logic   valid;
    owner_t owner;
  } entry_t;

  entry_t [SERIAL_NUM-1:0] entry_q, entry_d;
  owner_t                  ptr_q, ptr_d;
  logic [COUNT_BIT-1:0]    count_q, count_d;
  logic                    err_q, err_d;

  logic [REQ_PORT_NUM-1:0] arb_grant;
  owner_t                  winner;
  logic [SERIAL_BIT-1:0]   free_idx;
  logic                    full;
  logic                    grant_en;
  entry_t                  resp_entry;
  logic                    resp_live;

  mem_serial_rr_arbiter #(
    .PORT_NUM (REQ_PORT_NUM),
    .PTR_BIT  (OWNER_BIT)
  ) u_arb (
    .req_i   (bus.reqValid),
    .ptr_i   (ptr_q),
    .grant_o (arb_grant)
  );

  assign full = (count_q == COUNT_BIT'(SERIAL_NUM));

  // While rst is low the combinational outputs must read as idle, even if
  // requests or responses are still being driven.
  assign grant_en   = rst && (|bus.reqValid) && !full && bus.memReqReady;
  assign resp_entry = entry_q[bus.respSerial];
  assign resp_live  = rst && bus.respValid && resp_entry.valid;

  always_comb begin
    // NOTE: every combinational signal gets a default first so no path can infer a latch.
    free_idx = '0;
    winner   = '0;
    // A serial released this cycle still reads valid here, so it cannot be re-granted until the next cycle.
    for (int i = SERIAL_NUM - 1; i >= 0; i--) begin
      if (!entry_q[i].valid) free_idx = SERIAL_BIT'(i);
    end
    for (int i = 0; i < REQ_PORT_NUM; i++) begin
      if (arb_grant[i]) winner = OWNER_BIT'(i);
    end
  end

  always_comb begin
    bus.reqAck           = grant_en ? arb_grant : '0;
    bus.reqSerial        = free_idx;
    bus.memReqValid      = grant_en;
    bus.outstandingCount = count_q;
    bus.full             = full;
    bus.protocolError    = err_q;
    for (int i = 0; i < REQ_PORT_NUM; i++) begin
      bus.respPortValid[i] = resp_live && (resp_entry.owner == OWNER_BIT'(i));
    end
  end

  always_comb begin
    entry_d = entry_q;
    ptr_d   = ptr_q;
    err_d   = err_q | (rst && bus.respValid && !resp_entry.valid);
    count_d = count_q + COUNT_BIT'(grant_en) - COUNT_BIT'(resp_live);
    if (resp_live) entry_d[bus.respSerial].valid = 1'b0;
    if (grant_en) begin
      entry_d[free_idx].valid = 1'b1;
      entry_d[free_idx].owner = winner;
      ptr_d = (winner == OWNER_BIT'(REQ_PORT_NUM - 1)) ? '0 : winner + OWNER_BIT'(1);
    end
  end

  // NOTE: the entry table is reset, unlike a data RAM: its valid bits define which serials are free.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      entry_q <= '0;
      ptr_q   <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      entry_q <= entry_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

`ifdef RSD_MEM_SERIAL_TIMEOUT_EN
  localparam int AGE_BIT = $clog2(TIMEOUT_CYCLES) + 1;

  logic [SERIAL_NUM-1:0][AGE_BIT-1:0] age_q, age_d;
  logic                               to_q, to_d;
  logic [SERIAL_BIT-1:0]              to_serial_q, to_serial_d;
  logic                               hit;
  logic [SERIAL_BIT-1:0]              hit_idx;

  always_comb begin
    age_d       = age_q;
    to_d        = to_q;
    to_serial_d = to_serial_q;
    hit         = 1'b0;
    hit_idx     = '0;
    // Ages saturate at the limit; the entry stays live until its response arrives.
    for (int i = 0; i < SERIAL_NUM; i++) begin
      if (entry_q[i].valid && age_q[i] != AGE_BIT'(TIMEOUT_CYCLES)) age_d[i] = age_q[i] + AGE_BIT'(1);
    end
    for (int i = SERIAL_NUM - 1; i >= 0; i--) begin
      if (entry_q[i].valid && age_q[i] == AGE_BIT'(TIMEOUT_CYCLES)) begin
        hit     = 1'b1;
        hit_idx = SERIAL_BIT'(i);
      end
    end
    if (grant_en) age_d[free_idx] = '0;
    if (hit && !to_q) begin
      to_d        = 1'b1;
      to_serial_d = hit_idx;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      age_q       <= '0;
      to_q        <= 1'b0;
      to_serial_q <= '0;
    end else begin
      age_q       <= age_d;
      to_q        <= to_d;
      to_serial_q <= to_serial_d;
    end
  end

  assign bus.timeout       = to_q;
  assign bus.timeoutSerial = to_serial_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign bus.timeout        = 1'b0;
  assign bus.timeoutSerial  = '0;
`endif

endmodule
